// File: rtl/galois_lfsr_stream_if.sv
// galois_lfsr_stream_if: control, load and data stream signals of the LFSR word generator
interface galois_lfsr_stream_if #(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
);
  logic             start;
  logic             stop;
  logic             load_valid;
  logic [WIDTH-1:0] load_seed;
  logic             data_valid;
  logic             data_ready;
  logic [STEPS-1:0] data;
  logic [WIDTH-1:0] state_value;
  logic             lockup;
  modport master (
    output start, stop, load_valid, load_seed, data_ready,
    input  data_valid, data, state_value, lockup
  );
  modport slave (
    input  start, stop, load_valid, load_seed, data_ready,
    output data_valid, data, state_value, lockup
  );
endinterface

// File: rtl/galois_lfsr_stream.sv
// galois_lfsr_stream: Galois LFSR emitting STEPS bits per word over a valid/ready stream; GALOIS_LFSR_STREAM_LOCKUP_RECOVERY_EN replaces all-zero loads with SEED
module galois_lfsr_stream #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-2:0] TAPS  = 7'b0111000,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               STEPS = 1
) (
  input logic                 clock,
  input logic                 reset,
  galois_lfsr_stream_if.slave bus
);
`ifdef GALOIS_LFSR_STREAM_LOCKUP_RECOVERY_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} fsm_t;
  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [STEPS-1:0] data_q, data_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] adv_state;
  logic [STEPS-1:0] adv_word;
  logic             zero_load;
  assign zero_load = RECOVER && (bus.load_seed == '0);
  // unroll STEPS shifts of the current state into the next word and advanced state
  always_comb begin
    adv_state = lfsr_q;
    adv_word  = '0;
    for (int i = 0; i < STEPS; i++) begin
      adv_word[i] = adv_state[0];
      adv_state   = {adv_state[0], ({(WIDTH-1){adv_state[0]}} & TAPS) ^ adv_state[WIDTH-1:1]};
    end
  end
  // next-state logic: load beats stop beats start beats transfer
  always_comb begin
    fsm_d    = fsm_q;
    lfsr_d   = lfsr_q;
    data_d   = data_q;
    lockup_d = 1'b0;
    if (bus.load_valid) begin
      fsm_d    = IDLE;
      lfsr_d   = zero_load ? SEED : bus.load_seed;
      lockup_d = zero_load;
    end else if (fsm_q == RUN && bus.stop) begin
      fsm_d = IDLE;
    end else if (fsm_q == IDLE ? bus.start : bus.data_ready) begin
      fsm_d  = RUN;
      lfsr_d = adv_state;
      data_d = adv_word;
    end
  end
  // state registers with asynchronous reset to SEED / IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      lfsr_q   <= SEED;
      data_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      data_q   <= data_d;
      lockup_q <= lockup_d;
    end
  end
  assign bus.data_valid  = fsm_q == RUN;
  assign bus.data        = data_q;
  assign bus.state_value = lfsr_q;
  assign bus.lockup      = lockup_q;
endmodule

// File: tb/tb_galois_lfsr_stream.sv
// tb_galois_lfsr_stream: STEPS=1 and STEPS=4 instances checked against a polynomial-arithmetic model plus literal vectors
module tb_galois_lfsr_stream;
`ifdef GALOIS_LFSR_STREAM_LOCKUP_RECOVERY_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, lv = 1'b0, rdy = 1'b0;
  logic [7:0] seed = 8'h00;
  int checks = 0, errors = 0;
  galois_lfsr_stream_if #(.WIDTH(8), .STEPS(1)) if1 ();
  galois_lfsr_stream_if #(.WIDTH(8), .STEPS(4)) if4 ();
  assign if1.start = start;
  assign if1.stop = stop;
  assign if1.load_valid = lv;
  assign if1.load_seed = seed;
  assign if1.data_ready = rdy;
  assign if4.start = start;
  assign if4.stop = stop;
  assign if4.load_valid = lv;
  assign if4.load_seed = seed;
  assign if4.data_ready = rdy;
  galois_lfsr_stream #(.WIDTH(8), .TAPS(7'b0111000), .SEED(8'h01), .STEPS(1)) u1 (.clock(clock), .reset(reset), .bus(if1));
  galois_lfsr_stream #(.WIDTH(8), .TAPS(7'b0111000), .SEED(8'h01), .STEPS(4)) u4 (.clock(clock), .reset(reset), .bus(if4));
  always #5 clock = ~clock;
  // model: right shift, xor polynomial 0xB8 when the emitted bit is 1
  logic [7:0] ms[2];
  logic       mv[2];
  logic [3:0] md[2];
  logic       ml[2];
  function automatic void gen(input logic [7:0] s, input int n, output logic [7:0] so, output logic [3:0] w);
    w = 4'h0;
    for (int i = 0; i < n; i++) begin
      w[i] = s[0];
      s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    end
    so = s;
  endfunction
  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ms[k] = 8'h01; mv[k] = 1'b0; md[k] = 4'h0; ml[k] = 1'b0;
      end else begin
        ml[k] = 1'b0;
        if (lv) begin
          ms[k] = (REC && seed == 8'h00) ? 8'h01 : seed;
          ml[k] = REC && seed == 8'h00;
          mv[k] = 1'b0;
        end else if (mv[k] && stop) mv[k] = 1'b0;
        else if ((!mv[k] && start) || (mv[k] && rdy)) begin
          gen(ms[k], k ? 4 : 1, ms[k], md[k]);
          mv[k] = 1'b1;
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // per-cycle compare of both instances against the model
  always @(negedge clock) begin
    if (!reset) begin
      chk("u1.valid", 32'(if1.data_valid), 32'(mv[0]));
      chk("u1.data", 32'(if1.data), 32'(md[0][0]));
      chk("u1.state", 32'(if1.state_value), 32'(ms[0]));
      chk("u1.lockup", 32'(if1.lockup), 32'(ml[0]));
      chk("u4.valid", 32'(if4.data_valid), 32'(mv[1]));
      chk("u4.data", 32'(if4.data), 32'(md[1]));
      chk("u4.state", 32'(if4.state_value), 32'(ms[1]));
      chk("u4.lockup", 32'(if4.lockup), 32'(ml[1]));
    end
  end
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic load(input logic [7:0] v);
    lv = 1'b1; seed = v; start = 1'b0; stop = 1'b0;
    tick();
    lv = 1'b0;
  endtask
  logic [7:0] seq1_st[5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic       seq1_d[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    int n;
    #12;
    chk("reset.state", 32'(if1.state_value), 32'h01);
    chk("reset.valid", 32'(if1.data_valid), 32'h0);
    chk("reset.data4", 32'(if4.data), 32'h0);
    @(negedge clock); #1;
    reset = 1'b0;
    start = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      chk("seq1.data", 32'(if1.data), 32'(seq1_d[i]));
      chk("seq1.state", 32'(if1.state_value), 32'(seq1_st[i]));
    end
    load(8'h01);
    start = 1'b1; rdy = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold4.data", 32'(if4.data), 32'h1);
      chk("hold4.state", 32'(if4.state_value), 32'h17);
    end
    rdy = 1'b1;
    tick();
    chk("rel4.data", 32'(if4.data), 32'h7);
    chk("rel4.state", 32'(if4.state_value), 32'h64);
    lv = 1'b1; seed = 8'h5C; start = 1'b1;
    tick();
    lv = 1'b0; start = 1'b0;
    chk("ldstart.valid", 32'(if1.data_valid), 32'h0);
    chk("ldstart.state", 32'(if1.state_value), 32'h5C);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ldstart.data", 32'(if1.data), 32'h0);
    load(8'h01);
    start = 1'b1; rdy = 1'b1;
    n = 0;
    do begin
      tick();
      start = 1'b0;
      n++;
    end while (if1.state_value != 8'h01 && n < 300);
    chk("period", 32'(n), 32'd255);
    lv = 1'b1; seed = 8'h00;
    tick();
    lv = 1'b0;
    chk("zero.state", 32'(if1.state_value), REC ? 32'h01 : 32'h00);
    chk("zero.lockup", 32'(if1.lockup), 32'(REC));
    tick();
    chk("zero.lockup_end", 32'(if1.lockup), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    if (!REC) chk("zero.word", 32'(if4.data), 32'h0);
    load(8'hA5);
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      lv    = ($urandom_range(0, 31) == 0);
      seed  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    lv = 1'b0; stop = 1'b0; start = 1'b1; rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async.valid", 32'(if1.data_valid), 32'h0);
    chk("async.state", 32'(if1.state_value), 32'h01);
    chk("async.state4", 32'(if4.state_value), 32'h01);
    tick();
    reset = 1'b0;
    tick();
    chk("postreset.valid", 32'(if1.data_valid), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
